// File: rtl/uart_frame_rx.sv
// uart_frame_rx: 8N1 byte receiver plus frame-stream parser for the
// thermal-camera UART link. Bytes are paired low-first into words. Marker
// words frame each row, and every pixel word is emitted with its row and
// pixel address.
module uart_frame_rx #(
  parameter int          BIT_CYCLES   = 16,
  parameter logic [15:0] ID_FRAME     = 16'hFFFF,
  parameter logic [15:0] ID_ROW       = 16'hFFFE,
  parameter int          PIX_IN_ROW   = 384,
  parameter int          ROW_IN_FRAME = 288
) (
  input  logic        CLK_10,
  input  logic        RESET_N,
  input  logic        RX_UART,
  output logic [15:0] PIX_VALUE,
  output logic        PIX_VALID,
  output logic [9:0]  CNT_ROW_IN,
  output logic [9:0]  CNT_PIX_IN,
  output logic        FRAME_START,
  output logic        FRAME_DONE,
  output logic        SYNC,
  output logic        ERR
);

  localparam int            CW        = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [9:0]    PIX_LAST  = 10'(PIX_IN_ROW - 1);
  localparam logic [9:0]    ROW_LAST  = 10'(ROW_IN_FRAME);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic [1:0] {P_HUNT, P_ROW_ID, P_ROW_NUM, P_PIXELS} p_state_t;

  logic          rx_meta, rx_sync;
  rx_state_t     rx_state, rx_next;
  logic [CW-1:0] cyc_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          sample_tick;
  logic          byte_valid, frame_err;
  logic [7:0]    byte_data;

  p_state_t      p_state, p_next;
  logic          phase, phase_next;
  logic [7:0]    prev_byte;
  logic [9:0]    pix_idx;
  logic [15:0]   word;
  logic          start_n, err_n, pix_n, done_n, load_row;

  // Two-flop synchroniser; the line is assumed idle-high out of reset.
  always_ff @(posedge CLK_10 or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= RX_UART;
      rx_sync <= rx_meta;
    end
  end

  // Byte receiver state register.
  always_ff @(posedge CLK_10 or negedge RESET_N) begin
    if (!RESET_N) rx_state <= RX_IDLE;
    else          rx_state <= rx_next;
  end

  // Byte receiver next state and sample points (mid start bit, then every bit period).
  always_comb begin
    rx_next     = rx_state;
    sample_tick = 1'b0;
    case (rx_state)
      RX_IDLE:  if (!rx_sync) rx_next = RX_START;
      RX_START: if (cyc_cnt == HALF_LAST) begin
                  sample_tick = 1'b1;
                  rx_next     = rx_sync ? RX_IDLE : RX_DATA;
                end
      RX_DATA:  if (cyc_cnt == BIT_LAST) begin
                  sample_tick = 1'b1;
                  if (bit_idx == 3'd7) rx_next = RX_STOP;
                end
      RX_STOP:  if (cyc_cnt == BIT_LAST) begin
                  sample_tick = 1'b1;
                  rx_next     = rx_sync ? RX_IDLE : RX_BREAK;
                end
      RX_BREAK: if (rx_sync) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Bit timing, LSB-first shifting and the registered byte / framing-error strobes.
  always_ff @(posedge CLK_10 or negedge RESET_N) begin
    if (!RESET_N) begin
      cyc_cnt    <= '0;
      bit_idx    <= 3'd0;
      shift_reg  <= 8'd0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (rx_state == RX_IDLE || rx_state == RX_BREAK || sample_tick) cyc_cnt <= '0;
      else                                                          cyc_cnt <= cyc_cnt + 1'b1;
      if (rx_state == RX_START) bit_idx <= 3'd0;
      if (sample_tick && rx_state == RX_DATA) begin
        shift_reg <= {rx_sync, shift_reg[7:1]};
        bit_idx   <= bit_idx + 3'd1;
      end
      if (sample_tick && rx_state == RX_STOP) begin
        if (rx_sync) begin
          byte_valid <= 1'b1;
          byte_data  <= shift_reg;
        end else begin
          frame_err  <= 1'b1;
        end
      end
    end
  end

  assign word = {byte_data, prev_byte};
  assign SYNC = (p_state != P_HUNT);

  // Parser next state and strobe decisions, evaluated once per received byte.
  always_comb begin
    p_next     = p_state;
    phase_next = phase;
    start_n    = 1'b0;
    err_n      = 1'b0;
    pix_n      = 1'b0;
    done_n     = 1'b0;
    load_row   = 1'b0;
    if (frame_err) begin
      err_n      = 1'b1;
      p_next     = P_HUNT;
      phase_next = 1'b0;
    end else if (byte_valid) begin
      if (p_state == P_HUNT) begin
        if (word == ID_FRAME) begin
          start_n    = 1'b1;
          p_next     = P_ROW_ID;
          phase_next = 1'b0;
        end
      end else if (!phase) begin
        phase_next = 1'b1;
      end else begin
        phase_next = 1'b0;
        case (p_state)
          P_ROW_ID: begin
            if (word == ID_ROW)        p_next = P_ROW_NUM;
            else if (word == ID_FRAME) start_n = 1'b1;
            else begin
              err_n  = 1'b1;
              p_next = P_HUNT;
            end
          end
          P_ROW_NUM: begin
            if (word[15:10] == 6'd0 && word[9:0] != 10'd0 && word[9:0] <= ROW_LAST) begin
              load_row = 1'b1;
              p_next   = P_PIXELS;
            end else begin
              err_n  = 1'b1;
              p_next = P_HUNT;
            end
          end
          P_PIXELS: begin
            pix_n = 1'b1;
            if (pix_idx == PIX_LAST) begin
              if (CNT_ROW_IN == ROW_LAST) begin
                done_n = 1'b1;
                p_next = P_HUNT;
              end else begin
                p_next = P_ROW_ID;
              end
            end
          end
          default: p_next = P_HUNT;
        endcase
      end
    end
  end

  // Parser state, word pairing, addressing counters and registered output strobes.
  always_ff @(posedge CLK_10 or negedge RESET_N) begin
    if (!RESET_N) begin
      p_state     <= P_HUNT;
      phase       <= 1'b0;
      prev_byte   <= 8'd0;
      pix_idx     <= 10'd0;
      PIX_VALUE   <= 16'd0;
      PIX_VALID   <= 1'b0;
      CNT_ROW_IN  <= 10'd0;
      CNT_PIX_IN  <= 10'd0;
      FRAME_START <= 1'b0;
      FRAME_DONE  <= 1'b0;
      ERR         <= 1'b0;
    end else begin
      p_state     <= p_next;
      phase       <= phase_next;
      PIX_VALID   <= pix_n;
      FRAME_START <= start_n;
      FRAME_DONE  <= done_n;
      ERR         <= err_n;
      if (byte_valid) prev_byte <= byte_data;
      if (load_row) begin
        CNT_ROW_IN <= word[9:0];
        CNT_PIX_IN <= 10'd0;
        pix_idx    <= 10'd0;
      end
      if (pix_n) begin
        PIX_VALUE  <= word;
        CNT_PIX_IN <= pix_idx;
        pix_idx    <= pix_idx + 10'd1;
      end
    end
  end

endmodule
